// File: rtl/nts_api_dispatch_pkg.sv
// Shared constants for the NTS register-bus dispatcher: default address map,
// endpoint indices, error read pattern and a saturating counter helper.
package nts_api_dispatch_pkg;

  localparam int NTS_NUM_EP = 8;
  localparam int NTS_ADDR_W = 12;

  localparam int EP_ENGINE         = 0;
  localparam int EP_CLOCK          = 1;
  localparam int EP_COOKIE         = 2;
  localparam int EP_KEYMEM         = 3;
  localparam int EP_DEBUG          = 4;
  localparam int EP_PARSER         = 5;
  localparam int EP_NTPAUTH_KEYMEM = 6;
  localparam int EP_SPARE          = 7;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

  // Spare slot has base > last, so it never decodes.
  localparam logic [NTS_NUM_EP*NTS_ADDR_W-1:0] NTS_EP_BASE = {
    12'hFFF, 12'h300, 12'h200, 12'h180, 12'h080, 12'h020, 12'h010, 12'h000
  };
  localparam logic [NTS_NUM_EP*NTS_ADDR_W-1:0] NTS_EP_LAST = {
    12'h000, 12'h3FF, 12'h2FF, 12'h1F0, 12'h17F, 12'h03F, 12'h01F, 12'h00F
  };

  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/nts_api_dispatch_if.sv
// Host-side and endpoint-side register bus bundle of the NTS dispatcher.
interface nts_api_dispatch_if #(
  parameter int NUM_EP  = 8,
  parameter int ADDR_W  = 12,
  parameter int LOCAL_W = 8,
  parameter int DATA_W  = 32
);
  logic                     busy;
  logic                     external_cs;
  logic                     external_we;
  logic [ADDR_W-1:0]        external_address;
  logic [DATA_W-1:0]        external_write_data;
  logic [DATA_W-1:0]        external_read_data;
  logic                     external_read_data_valid;
  logic                     external_error;
  logic                     internal_we;
  logic [LOCAL_W-1:0]       internal_address;
  logic [DATA_W-1:0]        internal_write_data;
  logic [NUM_EP-1:0]        internal_cs;
  logic [NUM_EP*DATA_W-1:0] internal_read_data;

  modport master (
    input  busy,
    output external_cs, external_we, external_address, external_write_data,
    input  external_read_data, external_read_data_valid, external_error,
    input  internal_we, internal_address, internal_write_data, internal_cs,
    output internal_read_data
  );

  modport slave (
    output busy,
    input  external_cs, external_we, external_address, external_write_data,
    output external_read_data, external_read_data_valid, external_error,
    output internal_we, internal_address, internal_write_data, internal_cs,
    input  internal_read_data
  );
endinterface

// File: rtl/nts_api_decoder.sv
// Combinational address-range decoder: lowest-index hit wins, reports the
// endpoint-local offset and whether it overflows the local address width.
module nts_api_decoder #(
  parameter int NUM_EP  = 8,
  parameter int ADDR_W  = 12,
  parameter int LOCAL_W = 8,
  parameter logic [NUM_EP*ADDR_W-1:0] EP_BASE = '0,
  parameter logic [NUM_EP*ADDR_W-1:0] EP_LAST = '0
) (
  input  logic [ADDR_W-1:0]  address,
  output logic [NUM_EP-1:0]  hit,
  output logic [LOCAL_W-1:0] offset,
  output logic               oversize
);
  logic [ADDR_W:0]   diff [NUM_EP];
  logic [NUM_EP-1:0] in_range;
  logic [ADDR_W-1:0] full_off;

  // Range test done as (addr - base) <= (last - base) with a borrow bit, so an
  // empty range (last < base) simply never matches.
  for (genvar gi = 0; gi < NUM_EP; gi++) begin : g_ep
    localparam logic [ADDR_W:0] SPAN = {1'b0, EP_LAST[gi*ADDR_W +: ADDR_W]}
                                     - {1'b0, EP_BASE[gi*ADDR_W +: ADDR_W]};
    assign diff[gi]     = {1'b0, address} - {1'b0, EP_BASE[gi*ADDR_W +: ADDR_W]};
    assign in_range[gi] = !SPAN[ADDR_W] && (diff[gi] <= SPAN);
  end

  always_comb begin
    hit      = '0;
    full_off = '0;
    for (int i = NUM_EP - 1; i >= 0; i--) begin
      if (in_range[i]) begin
        hit      = '0;
        hit[i]   = 1'b1;
        full_off = diff[i][ADDR_W-1:0];
      end
    end
  end

  assign offset   = full_off[LOCAL_W-1:0];
  assign oversize = (|hit) && ((full_off >> LOCAL_W) != '0);
endmodule

// File: rtl/nts_api_dispatch.sv
// Pipelined demux of the external 32-bit register bus onto NUM_EP endpoints,
// with error completions, write acks and saturating drop/error counters.
module nts_api_dispatch
  import nts_api_dispatch_pkg::*;
#(
  parameter int NUM_EP     = NTS_NUM_EP,
  parameter int ADDR_W     = NTS_ADDR_W,
  parameter int LOCAL_W    = 8,
  parameter int DATA_W     = 32,
  parameter logic [NUM_EP*ADDR_W-1:0] EP_BASE = NTS_EP_BASE,
  parameter logic [NUM_EP*ADDR_W-1:0] EP_LAST = NTS_EP_LAST,
  parameter int RD_LATENCY = 1,
  parameter logic [DATA_W-1:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  nts_api_dispatch_if.slave   bus,
  output logic [15:0]         drop_count,
  output logic [15:0]         err_count
);
  logic                busy_reg, accept, done, mapped;
  logic                p0_vld_reg, p0_we_reg;
  logic [ADDR_W-1:0]   p0_addr_reg;
  logic [DATA_W-1:0]   p0_wdata_reg;
  logic [NUM_EP-1:0]   dec_hit, cs_reg, sel_reg;
  logic [LOCAL_W-1:0]  dec_offset, int_addr_reg;
  logic                dec_oversize, int_we_reg, req_we_reg, req_err_reg;
  logic [DATA_W-1:0]   int_wdata_reg, ep_data, rdata_reg;
  logic [RD_LATENCY:0] dly_reg;
  logic                valid_reg, error_reg;
  logic [15:0]         drop_reg, err_reg;

  nts_api_decoder #(
    .NUM_EP(NUM_EP), .ADDR_W(ADDR_W), .LOCAL_W(LOCAL_W),
    .EP_BASE(EP_BASE), .EP_LAST(EP_LAST)
  ) u_decoder (
    .address(p0_addr_reg), .hit(dec_hit), .offset(dec_offset), .oversize(dec_oversize)
  );

  assign accept = bus.external_cs && !busy_reg;
  assign mapped = (|dec_hit) && !dec_oversize;
  // dly_reg[0] marks the internal-cs cycle; bit RD_LATENCY is the capture cycle.
  assign done   = dly_reg[RD_LATENCY];

  always_comb begin
    ep_data = '0;
    for (int i = 0; i < NUM_EP; i++) begin
      if (sel_reg[i]) ep_data = ep_data | bus.internal_read_data[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg      <= 1'b0;
      p0_vld_reg    <= 1'b0;
      p0_we_reg     <= 1'b0;
      p0_addr_reg   <= '0;
      p0_wdata_reg  <= '0;
      dly_reg       <= '0;
      cs_reg        <= '0;
      sel_reg       <= '0;
      int_we_reg    <= 1'b0;
      int_addr_reg  <= '0;
      int_wdata_reg <= '0;
      req_we_reg    <= 1'b0;
      req_err_reg   <= 1'b0;
      valid_reg     <= 1'b0;
      error_reg     <= 1'b0;
      rdata_reg     <= '0;
      drop_reg      <= '0;
      err_reg       <= '0;
    end else begin
      busy_reg   <= accept ? 1'b1 : (done ? 1'b0 : busy_reg);
      p0_vld_reg <= accept;
      if (accept) begin
        p0_we_reg    <= bus.external_we;
        p0_addr_reg  <= bus.external_address;
        p0_wdata_reg <= bus.external_write_data;
      end
      dly_reg <= {dly_reg[RD_LATENCY-1:0], p0_vld_reg};

      cs_reg        <= '0;
      int_we_reg    <= 1'b0;
      int_addr_reg  <= '0;
      int_wdata_reg <= '0;
      if (p0_vld_reg) begin
        sel_reg     <= mapped ? dec_hit : '0;
        req_we_reg  <= p0_we_reg;
        req_err_reg <= !mapped;
        if (mapped) begin
          cs_reg        <= dec_hit;
          int_we_reg    <= p0_we_reg;
          int_addr_reg  <= dec_offset;
          int_wdata_reg <= p0_wdata_reg;
        end
      end

      valid_reg <= done;
      error_reg <= done && req_err_reg;
      rdata_reg <= '0;
      if (done) rdata_reg <= req_err_reg ? ERR_DATA : (req_we_reg ? '0 : ep_data);

      if (bus.external_cs && busy_reg) drop_reg <= sat_inc(drop_reg);
      if (done && req_err_reg)         err_reg  <= sat_inc(err_reg);
    end
  end

  assign bus.busy                     = busy_reg;
  assign bus.external_read_data       = rdata_reg;
  assign bus.external_read_data_valid = valid_reg;
  assign bus.external_error           = error_reg;
  assign bus.internal_cs              = cs_reg;
  assign bus.internal_we              = int_we_reg;
  assign bus.internal_address         = int_addr_reg;
  assign bus.internal_write_data      = int_wdata_reg;
  assign drop_count                   = drop_reg;
  assign err_count                    = err_reg;
endmodule

// File: tb/tb_nts_api_dispatch.sv
// Directed bench: default NTS map at RD_LATENCY=1, plus a 2-endpoint overlapping
// map at RD_LATENCY=3 for capture timing, overlap priority and oversize errors.
module tb_nts_api_dispatch;
  import nts_api_dispatch_pkg::*;

  localparam logic [23:0] B_BASE = {12'h080, 12'h000};
  localparam logic [23:0] B_LAST = {12'h0FF, 12'h1FF};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nts_api_dispatch_if #(.NUM_EP(8), .ADDR_W(12), .LOCAL_W(8), .DATA_W(32)) bus_a ();
  nts_api_dispatch_if #(.NUM_EP(2), .ADDR_W(12), .LOCAL_W(8), .DATA_W(32)) bus_b ();
  logic [15:0] drop_a, err_a, drop_b, err_b;

  nts_api_dispatch #(
    .NUM_EP(8), .ADDR_W(12), .LOCAL_W(8), .DATA_W(32),
    .EP_BASE(NTS_EP_BASE), .EP_LAST(NTS_EP_LAST),
    .RD_LATENCY(1), .ERR_DATA(32'hDEADBEEF)
  ) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a), .drop_count(drop_a), .err_count(err_a));

  nts_api_dispatch #(
    .NUM_EP(2), .ADDR_W(12), .LOCAL_W(8), .DATA_W(32),
    .EP_BASE(B_BASE), .EP_LAST(B_LAST),
    .RD_LATENCY(3), .ERR_DATA(32'hDEADBEEF)
  ) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b), .drop_count(drop_b), .err_count(err_b));

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [7:0]  exp_cs;
    logic [7:0]  exp_iaddr;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [12];
  int total = 0;
  int bad = 0;
  int exp_errs = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic cs, input logic we, input logic [11:0] addr, input logic [31:0] wd);
    bus_a.external_cs = cs;
    bus_a.external_we = we;
    bus_a.external_address = addr;
    bus_a.external_write_data = wd;
  endtask

  task automatic drive_b(input logic cs, input logic [11:0] addr);
    bus_b.external_cs = cs;
    bus_b.external_we = 1'b0;
    bus_b.external_address = addr;
    bus_b.external_write_data = '0;
  endtask

  task automatic set_ep0_b(input logic [31:0] v);
    bus_b.internal_read_data = {32'hBBBB0001, v};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b0, 12'h012, 32'h0,        8'h02, 8'h02, 32'h11223344, 1'b0};
    vecs[1]  = '{1'b1, 12'h0A5, 32'hCAFEF00D, 8'h08, 8'h25, 32'h00000000, 1'b0};
    vecs[2]  = '{1'b0, 12'h040, 32'h0,        8'h00, 8'h00, 32'hDEADBEEF, 1'b1};
    vecs[3]  = '{1'b0, 12'h000, 32'h0,        8'h01, 8'h00, 32'h0BAD0000, 1'b0};
    vecs[4]  = '{1'b0, 12'h00F, 32'h0,        8'h01, 8'h0F, 32'h0BAD0000, 1'b0};
    vecs[5]  = '{1'b0, 12'h17F, 32'h0,        8'h08, 8'hFF, 32'h33333333, 1'b0};
    vecs[6]  = '{1'b0, 12'h180, 32'h0,        8'h10, 8'h00, 32'h44444444, 1'b0};
    vecs[7]  = '{1'b0, 12'h1F1, 32'h0,        8'h00, 8'h00, 32'hDEADBEEF, 1'b1};
    vecs[8]  = '{1'b1, 12'h3FF, 32'h12345678, 8'h40, 8'hFF, 32'h00000000, 1'b0};
    vecs[9]  = '{1'b1, 12'h400, 32'hA5A5A5A5, 8'h00, 8'h00, 32'hDEADBEEF, 1'b1};
    vecs[10] = '{1'b0, 12'h2AB, 32'h0,        8'h20, 8'hAB, 32'h55555555, 1'b0};
    vecs[11] = '{1'b0, 12'h03F, 32'h0,        8'h04, 8'h1F, 32'h22222222, 1'b0};

    bus_a.internal_read_data = {32'h77777777, 32'h66666666, 32'h55555555, 32'h44444444,
                                32'h33333333, 32'h22222222, 32'h11223344, 32'h0BAD0000};
    set_ep0_b(32'h0);
    drive_a(1'b0, 1'b0, 12'h0, 32'h0);
    drive_b(1'b0, 12'h0);

    // Reset state
    tick(); tick();
    check("rst_valid", 32'(bus_a.external_read_data_valid), 32'h0);
    check("rst_rdata", bus_a.external_read_data, 32'h0);
    check("rst_error", 32'(bus_a.external_error), 32'h0);
    check("rst_busy", 32'(bus_a.busy), 32'h0);
    check("rst_cs", 32'(bus_a.internal_cs), 32'h0);
    check("rst_counts", {drop_a, err_a}, 32'h0);
    rst_n = 1'b1;
    tick();

    // Table-driven single transactions on the default map
    for (int k = 0; k < 12; k++) begin
      drive_a(1'b1, vecs[k].we, vecs[k].addr, vecs[k].wdata);
      tick();
      drive_a(1'b0, 1'b0, 12'h0, 32'h0);
      check("busy_t1", 32'(bus_a.busy), 32'h1);
      tick();
      check("cs_t2", 32'(bus_a.internal_cs), 32'(vecs[k].exp_cs));
      check("iaddr_t2", 32'(bus_a.internal_address), 32'(vecs[k].exp_iaddr));
      if (vecs[k].exp_cs != 8'h00) begin
        check("iwe_t2", 32'(bus_a.internal_we), 32'(vecs[k].we));
        check("iwdata_t2", bus_a.internal_write_data, vecs[k].we ? vecs[k].wdata : 32'h0);
      end
      tick();
      check("cs_t3", 32'(bus_a.internal_cs), 32'h0);
      check("valid_t3", 32'(bus_a.external_read_data_valid), 32'h0);
      check("error_t3", 32'(bus_a.external_error), 32'h0);
      tick();
      if (vecs[k].exp_err) exp_errs++;
      check("valid_t4", 32'(bus_a.external_read_data_valid), 32'h1);
      check("rdata_t4", bus_a.external_read_data, vecs[k].exp_rdata);
      check("error_t4", 32'(bus_a.external_error), 32'(vecs[k].exp_err));
      check("busy_t4", 32'(bus_a.busy), 32'h0);
      check("err_count", 32'(err_a), 32'(exp_errs));
      $display("txn %0d: we=%0b addr=0x%03h cs=0x%02h rdata=0x%08h err=%0b",
               k, vecs[k].we, vecs[k].addr, vecs[k].exp_cs,
               bus_a.external_read_data, bus_a.external_error);
      tick();
    end

    // Drop while busy, then accept in the valid cycle
    drive_a(1'b1, 1'b0, 12'h012, 32'h0);
    tick();
    drive_a(1'b1, 1'b0, 12'h000, 32'h0);
    check("drop_busy", 32'(bus_a.busy), 32'h1);
    tick();
    drive_a(1'b0, 1'b0, 12'h0, 32'h0);
    check("drop_count", 32'(drop_a), 32'h1);
    check("drop_cs", 32'(bus_a.internal_cs), 32'h02);
    tick(); tick();
    check("drop_valid", 32'(bus_a.external_read_data_valid), 32'h1);
    check("drop_rdata", bus_a.external_read_data, 32'h11223344);
    check("drop_busy_low", 32'(bus_a.busy), 32'h0);
    $display("txn drop: first read 0x012 done, second request dropped");
    drive_a(1'b1, 1'b0, 12'h180, 32'h0);
    tick();
    drive_a(1'b0, 1'b0, 12'h0, 32'h0);
    check("b2b_busy", 32'(bus_a.busy), 32'h1);
    check("b2b_drop_kept", 32'(drop_a), 32'h1);
    tick();
    check("b2b_cs", 32'(bus_a.internal_cs), 32'h10);
    tick();
    check("b2b_valid_t3", 32'(bus_a.external_read_data_valid), 32'h0);
    tick();
    check("b2b_valid_t4", 32'(bus_a.external_read_data_valid), 32'h1);
    check("b2b_rdata", bus_a.external_read_data, 32'h44444444);
    $display("txn b2b: read 0x180 accepted in valid cycle rdata=0x%08h", bus_a.external_read_data);
    tick();

    // RD_LATENCY=3: overlap priority and capture cycle
    drive_b(1'b1, 12'h090);
    tick();
    drive_b(1'b0, 12'h0);
    tick();
    check("lat3_cs", 32'(bus_b.internal_cs), 32'h1);
    check("lat3_iaddr", 32'(bus_b.internal_address), 32'h90);
    tick(); set_ep0_b(32'hAAAA0003);
    tick(); set_ep0_b(32'hAAAA0004);
    tick(); set_ep0_b(32'hAAAA0005);
    check("lat3_valid_t5", 32'(bus_b.external_read_data_valid), 32'h0);
    tick(); set_ep0_b(32'hAAAA0006);
    check("lat3_valid_t6", 32'(bus_b.external_read_data_valid), 32'h1);
    check("lat3_rdata", bus_b.external_read_data, 32'hAAAA0005);
    check("lat3_error", 32'(bus_b.external_error), 32'h0);
    $display("txn lat3: read 0x090 rdata=0x%08h", bus_b.external_read_data);
    tick();

    // Oversize offset inside a mapped range
    drive_b(1'b1, 12'h150);
    tick();
    drive_b(1'b0, 12'h0);
    tick();
    check("ovs_cs", 32'(bus_b.internal_cs), 32'h0);
    tick(); tick(); tick();
    check("ovs_valid_t5", 32'(bus_b.external_read_data_valid), 32'h0);
    tick();
    check("ovs_valid", 32'(bus_b.external_read_data_valid), 32'h1);
    check("ovs_error", 32'(bus_b.external_error), 32'h1);
    check("ovs_rdata", bus_b.external_read_data, 32'hDEADBEEF);
    check("ovs_err_count", 32'(err_b), 32'h1);
    $display("txn ovs: read 0x150 err=%0b", bus_b.external_error);
    tick();

    // Reset during a read aborts it
    drive_a(1'b1, 1'b0, 12'h012, 32'h0);
    tick();
    drive_a(1'b0, 1'b0, 12'h0, 32'h0);
    tick();
    check("abort_cs_pre", 32'(bus_a.internal_cs), 32'h02);
    rst_n = 1'b0;
    #1;
    check("abort_cs", 32'(bus_a.internal_cs), 32'h0);
    check("abort_busy", 32'(bus_a.busy), 32'h0);
    check("abort_counts", {drop_a, err_a}, 32'h0);
    tick();
    check("abort_valid_t3", 32'(bus_a.external_read_data_valid), 32'h0);
    tick();
    check("abort_valid_t4", 32'(bus_a.external_read_data_valid), 32'h0);
    check("abort_rdata_t4", bus_a.external_read_data, 32'h0);
    $display("txn abort: read 0x012 aborted by reset");
    rst_n = 1'b1;
    tick();
    drive_a(1'b1, 1'b0, 12'h012, 32'h0);
    tick();
    drive_a(1'b0, 1'b0, 12'h0, 32'h0);
    tick(); tick(); tick();
    check("post_rst_valid", 32'(bus_a.external_read_data_valid), 32'h1);
    check("post_rst_rdata", bus_a.external_read_data, 32'h11223344);
    $display("txn post-reset: read 0x012 rdata=0x%08h", bus_a.external_read_data);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
